mips_ctrl_fsm: RTL and testbench

MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

---
 rtl/mips_ctrl_fsm.sv | 191 +++++++++++++++++++
 tb/tb_mips_ctrl_fsm.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_fsm.sv
// rtl/mips_ctrl_fsm.sv - multicycle MIPS control FSM with byte-serial instruction fetch
// Optional ADDI support is compiled in when MIPS_CTRL_ADDI_EN is defined.
module mips_ctrl_fsm #(
    parameter int FETCH_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic                   mem_ready,
    output logic                   memwrite,
    output logic                   alusrca,
    output logic                   memtoreg,
    output logic                   iord,
    output logic                   pcwrite,
    output logic                   brnch,
    output logic                   brnch_ne,
    output logic                   regwrite,
    output logic                   regdst,
    output logic [1:0]             pcsrc,
    output logic [1:0]             alusrcb,
    output logic [1:0]             aluop,
    output logic [FETCH_BYTES-1:0] irwrite,
    output logic                   illegal_op,
    output logic [3:0]             state_o
);

    localparam int            KW     = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(FETCH_BYTES - 1);

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        LBRD    = 4'd3,
        LBWR    = 4'd4,
        SBWR    = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWR = 4'd7,
        BEQEX   = 4'd8,
        BNEEX   = 4'd9,
        JEX     = 4'd10,
`ifdef MIPS_CTRL_ADDI_EN
        ADDIEX  = 4'd11,
        ADDIWR  = 4'd12,
`endif
        TRAP    = 4'd13
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    // op is only looked at in DECODE, so remember load-vs-store for MEMADR
    logic            is_sb_q, is_sb_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            k_q     <= '0;
            is_sb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            is_sb_q <= is_sb_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        k_d        = k_q;
        is_sb_d    = is_sb_q;
        memwrite   = 1'b0;
        alusrca    = 1'b0;
        memtoreg   = 1'b0;
        iord       = 1'b0;
        pcwrite    = 1'b0;
        brnch      = 1'b0;
        brnch_ne   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        pcsrc      = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        irwrite    = '0;
        illegal_op = 1'b0;
        state_o    = 4'd0;

        if (!reset) begin
            state_o = state_q;
            case (state_q)
                FETCH: begin
                    alusrcb = 2'b01;
                    pcwrite = mem_ready;
                    for (int i = 0; i < FETCH_BYTES; i++) begin
                        irwrite[i] = mem_ready && (k_q == KW'(i));
                    end
                    state_d = FETCH;
                    if (mem_ready) begin
                        if (k_q == K_LAST) begin
                            k_d     = '0;
                            state_d = DECODE;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    is_sb_d = (op == OP_SB);
                    case (op)
                        OP_LB, OP_SB: state_d = MEMADR;
                        OP_RTYPE:     state_d = RTYPEEX;
                        OP_BEQ:       state_d = BEQEX;
                        OP_BNE:       state_d = BNEEX;
                        OP_J:         state_d = JEX;
`ifdef MIPS_CTRL_ADDI_EN
                        OP_ADDI:      state_d = ADDIEX;
`endif
                        default:      state_d = TRAP;
                    endcase
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    state_d = is_sb_q ? SBWR : LBRD;
                end
                LBRD: begin
                    iord    = 1'b1;
                    state_d = mem_ready ? LBWR : LBRD;
                end
                LBWR: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                SBWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    state_d  = mem_ready ? FETCH : SBWR;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                    state_d = RTYPEWR;
                end
                RTYPEWR: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                BEQEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    brnch   = 1'b1;
                    pcsrc   = 2'b01;
                end
                BNEEX: begin
                    alusrca  = 1'b1;
                    aluop    = 2'b01;
                    brnch_ne = 1'b1;
                    pcsrc    = 2'b01;
                end
                JEX: begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b10;
                end
`ifdef MIPS_CTRL_ADDI_EN
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    state_d = ADDIWR;
                end
                ADDIWR: begin
                    regwrite = 1'b1;
                end
`endif
                TRAP: begin
                    illegal_op = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// tb/tb_mips_ctrl_fsm.sv - directed bench with route-table model for mips_ctrl_fsm (FETCH_BYTES 4 and 2)
module tb_mips_ctrl_fsm;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    typedef struct packed {
        logic       mw;
        logic       asa;
        logic       mtr;
        logic       iord;
        logic       pcw;
        logic       br;
        logic       bne;
        logic       rw;
        logic       rd;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       ill;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = OP_RTYPE;
    logic       mr_a = 1'b1;
    logic       mr_b = 1'b1;

    logic memwrite_a, alusrca_a, memtoreg_a, iord_a, pcwrite_a, brnch_a, brnch_ne_a, regwrite_a, regdst_a, illegal_op_a;
    logic memwrite_b, alusrca_b, memtoreg_b, iord_b, pcwrite_b, brnch_b, brnch_ne_b, regwrite_b, regdst_b, illegal_op_b;
    logic [1:0] pcsrc_a, alusrcb_a, aluop_a, pcsrc_b, alusrcb_b, aluop_b;
    logic [3:0] irwrite_a, state_a, state_b;
    logic [1:0] irwrite_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_ctrl_fsm #(.FETCH_BYTES(4)) dut_a (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mr_a),
        .memwrite(memwrite_a), .alusrca(alusrca_a), .memtoreg(memtoreg_a), .iord(iord_a),
        .pcwrite(pcwrite_a), .brnch(brnch_a), .brnch_ne(brnch_ne_a), .regwrite(regwrite_a),
        .regdst(regdst_a), .pcsrc(pcsrc_a), .alusrcb(alusrcb_a), .aluop(aluop_a),
        .irwrite(irwrite_a), .illegal_op(illegal_op_a), .state_o(state_a)
    );

    mips_ctrl_fsm #(.FETCH_BYTES(2)) dut_b (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mr_b),
        .memwrite(memwrite_b), .alusrca(alusrca_b), .memtoreg(memtoreg_b), .iord(iord_b),
        .pcwrite(pcwrite_b), .brnch(brnch_b), .brnch_ne(brnch_ne_b), .regwrite(regwrite_b),
        .regdst(regdst_b), .pcsrc(pcsrc_b), .alusrcb(alusrcb_b), .aluop(aluop_b),
        .irwrite(irwrite_b), .illegal_op(illegal_op_b), .state_o(state_b)
    );

    logic [15:0] act_c [2];
    logic [3:0]  act_ir [2];
    logic [3:0]  act_st [2];
    assign act_c[0]  = {memwrite_a, alusrca_a, memtoreg_a, iord_a, pcwrite_a, brnch_a, brnch_ne_a,
                        regwrite_a, regdst_a, pcsrc_a, alusrcb_a, aluop_a, illegal_op_a};
    assign act_c[1]  = {memwrite_b, alusrca_b, memtoreg_b, iord_b, pcwrite_b, brnch_b, brnch_ne_b,
                        regwrite_b, regdst_b, pcsrc_b, alusrcb_b, aluop_b, illegal_op_b};
    assign act_ir[0] = irwrite_a;
    assign act_ir[1] = {2'b00, irwrite_b};
    assign act_st[0] = state_a;
    assign act_st[1] = state_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Post-DECODE state path of each opcode, low nibble first, zero-terminated (back to FETCH).
    function automatic logic [15:0] route_for(input logic [5:0] o);
        case (o)
            OP_LB:    route_for = 16'h0432;
            OP_SB:    route_for = 16'h0052;
            OP_RTYPE: route_for = 16'h0076;
            OP_BEQ:   route_for = 16'h0008;
            OP_BNE:   route_for = 16'h0009;
            OP_J:     route_for = 16'h000A;
`ifdef MIPS_CTRL_ADDI_EN
            OP_ADDI:  route_for = 16'h00CB;
`endif
            default:  route_for = 16'h000D;
        endcase
    endfunction

    function automatic ctrl_t exp_ctrl(input int st, input logic mr);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.pcw = mr; c.alusrcb = 2'b01; end
            1:  c.alusrcb = 2'b11;
            2:  begin c.asa = 1'b1; c.alusrcb = 2'b10; end
            3:  c.iord = 1'b1;
            4:  begin c.rw = 1'b1; c.mtr = 1'b1; end
            5:  begin c.iord = 1'b1; c.mw = 1'b1; end
            6:  begin c.asa = 1'b1; c.aluop = 2'b10; end
            7:  begin c.rd = 1'b1; c.rw = 1'b1; end
            8:  begin c.asa = 1'b1; c.aluop = 2'b01; c.br = 1'b1; c.pcsrc = 2'b01; end
            9:  begin c.asa = 1'b1; c.aluop = 2'b01; c.bne = 1'b1; c.pcsrc = 2'b01; end
            10: begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
            11: begin c.asa = 1'b1; c.alusrcb = 2'b10; end
            12: c.rw = 1'b1;
            13: c.ill = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    int          m_cur [2] = '{0, 0};
    int          m_k   [2] = '{0, 0};
    logic [15:0] m_rt  [2] = '{16'h0, 16'h0};
    int          m_fb  [2] = '{4, 2};

    always @(negedge clk) begin
        logic        mr;
        logic [15:0] ec;
        logic [3:0]  eir;
        logic [3:0]  est;
        for (int i = 0; i < 2; i++) begin
            mr = (i == 0) ? mr_a : mr_b;
            if (reset) begin
                ec = '0; eir = '0; est = '0;
            end else begin
                ec  = exp_ctrl(m_cur[i], mr);
                eir = (m_cur[i] == 0 && mr) ? 4'(1 << m_k[i]) : 4'd0;
                est = 4'(m_cur[i]);
            end
            chk((i == 0) ? "model_ctrl_fb4" : "model_ctrl_fb2", act_c[i], ec);
            chk((i == 0) ? "model_irwrite_fb4" : "model_irwrite_fb2", act_ir[i], eir);
            chk((i == 0) ? "model_state_fb4" : "model_state_fb2", act_st[i], est);
            if (reset) begin
                m_cur[i] = 0; m_k[i] = 0; m_rt[i] = '0;
            end else begin
                case (m_cur[i])
                    0: if (mr) begin
                        m_k[i]++;
                        if (m_k[i] == m_fb[i]) begin m_k[i] = 0; m_cur[i] = 1; end
                    end
                    1: begin
                        m_rt[i]  = route_for(op);
                        m_cur[i] = int'(m_rt[i][3:0]);
                        m_rt[i]  = m_rt[i] >> 4;
                    end
                    3, 5: if (mr) begin
                        m_cur[i] = int'(m_rt[i][3:0]);
                        m_rt[i]  = m_rt[i] >> 4;
                    end
                    default: begin
                        m_cur[i] = int'(m_rt[i][3:0]);
                        m_rt[i]  = m_rt[i] >> 4;
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic latency(input logic [5:0] o, input int exp, input string nm);
        int n;
        bit seen;
        bit done;
        op = o; mr_a = 1'b1; mr_b = 1'b1;
        do_reset();
        n = 0; seen = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (seen && state_a == 4'd0) done = 1;
            else begin
                n++;
                if (state_a != 4'd0) seen = 1;
                step();
            end
        end
        chk(nm, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_ir [7] = '{1, 2, 4, 8, 0, 0, 0};
        int exp_st [7] = '{0, 0, 0, 0, 1, 6, 7};
        int pulses;

        chk("route_lb", route_for(OP_LB), 16'h0432);
        chk("route_bad", route_for(OP_BAD), 16'h000D);

        // Reset for two edges; outputs forced low even with mem_ready=1
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_state", state_a, 0);
        chk("reset_irwrite", irwrite_a, 0);
        chk("reset_pcwrite", pcwrite_a, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("rtype_irwrite", irwrite_a, exp_ir[c]);
            chk("rtype_state", state_a, exp_st[c]);
            chk("rtype_regwrite", regwrite_a & regdst_a, (c == 6) ? 1 : 0);
            step();
        end
        @(negedge clk);
        chk("rtype_back_fetch", state_a, 0);

        // LB with three memory wait cycles in LBRD
        op = OP_LB; mr_a = 1'b1; mr_b = 1'b1;
        do_reset();
        repeat (6) step();
        mr_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("lb_wait_state", state_a, 3);
            chk("lb_wait_iord", iord_a, 1);
            step();
        end
        mr_a = 1'b1;
        @(negedge clk);
        chk("lb_ready_state", state_a, 3);
        step();
        @(negedge clk);
        chk("lbwr_state", state_a, 4);
        chk("lbwr_mtr_rw", {memtoreg_a, regwrite_a}, 2'b11);
        step();
        @(negedge clk);
        chk("lb_back_fetch", state_a, 0);

        // BNE and J
        op = OP_BNE;
        do_reset();
        repeat (5) step();
        @(negedge clk);
        chk("bne_state", state_a, 9);
        chk("bne_flags", {brnch_ne_a, brnch_a, pcsrc_a, aluop_a}, 6'b10_01_01);
        op = OP_J;
        do_reset();
        repeat (5) step();
        @(negedge clk);
        chk("j_state", state_a, 10);
        chk("j_flags", {pcwrite_a, pcsrc_a}, 3'b1_10);

        // Undecodable opcode: one-cycle trap
        op = OP_BAD;
        do_reset();
        repeat (5) step();
        @(negedge clk);
        chk("trap_state", state_a, 13);
        chk("trap_ill", illegal_op_a, 1);
        step();
        @(negedge clk);
        chk("trap_exit_state", state_a, 0);
        chk("trap_exit_ill", illegal_op_a, 0);

        op = OP_ADDI;
        do_reset();
        repeat (5) step();
        @(negedge clk);
`ifdef MIPS_CTRL_ADDI_EN
        chk("addi_ex_state", state_a, 11);
        step();
        @(negedge clk);
        chk("addi_wr_state", state_a, 12);
        chk("addi_wr_rw", regwrite_a, 1);
`else
        chk("addi_trap_state", state_a, 13);
        chk("addi_trap_ill", illegal_op_a, 1);
        step();
        @(negedge clk);
        chk("addi_trap_exit", state_a, 0);
`endif

        // Latencies with mem_ready tied high, fetch included
        latency(OP_J, 6, "lat_j");
        latency(OP_BEQ, 6, "lat_beq");
        latency(OP_BNE, 6, "lat_bne");
        latency(OP_RTYPE, 7, "lat_rtype");
        latency(OP_SB, 7, "lat_sb");
        latency(OP_LB, 8, "lat_lb");
`ifdef MIPS_CTRL_ADDI_EN
        latency(OP_ADDI, 7, "lat_addi");
`endif

        // Two-byte fetch with a stall in the middle
        op = OP_RTYPE; mr_a = 1'b1; mr_b = 1'b1;
        do_reset();
        pulses = 0;
        @(negedge clk);
        chk("fb2_ir0", irwrite_b, 2'b01);
        pulses += int'(pcwrite_b);
        step();
        mr_b = 1'b0;
        @(negedge clk);
        chk("fb2_ir_stall", irwrite_b, 2'b00);
        chk("fb2_state_stall", state_b, 0);
        pulses += int'(pcwrite_b);
        step();
        mr_b = 1'b1;
        @(negedge clk);
        chk("fb2_ir1", irwrite_b, 2'b10);
        pulses += int'(pcwrite_b);
        step();
        @(negedge clk);
        chk("fb2_decode", state_b, 1);
        chk("fb2_pcw_pulses", pulses, 2);

        // Reset while stalled in SBWR
        op = OP_SB; mr_a = 1'b1; mr_b = 1'b1;
        do_reset();
        repeat (6) step();
        mr_a = 1'b0;
        @(negedge clk);
        chk("sbwr_state", state_a, 5);
        chk("sbwr_mw_iord", {memwrite_a, iord_a}, 2'b11);
        step();
        @(negedge clk);
        chk("sbwr_hold", state_a, 5);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("sbwr_reset_mw", memwrite_a, 0);
        chk("sbwr_reset_state", state_a, 0);
        step();
        reset = 1'b0;
        mr_a = 1'b1;
        @(negedge clk);
        chk("post_reset_state", state_a, 0);
        chk("post_reset_ir", irwrite_a, 4'b0001);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
